// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, frame
// geometry and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter with synchronous clear; bit_tick_o marks the
// last clock of each serial bit.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == LastCnt);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a ring-buffer FIFO and serialises each one as a UART frame:
// start, 8 data bits LSB first, optional parity, one stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_read_data_i,
    output logic       fifo_read_en_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    state_e               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic [2:0]           bit_cnt_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 frame_done_q;
    logic                 bit_tick;

    // Bit timing restarts so the start bit lasts exactly one full period.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == StFetch),
        .bit_tick_o(bit_tick)
    );

    assign fifo_read_en_o = (state_q == StIdle) & enable_i & ~fifo_empty_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (fifo_read_en_o) begin
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    shift_q <= fifo_read_data_i;
                    data_q  <= fifo_read_data_i;
                    tx_q    <= 1'b0;
                    state_q <= StStart;
                end
                StStart: begin
                    if (bit_tick) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LastBit) begin
                            if (PARITY_EN) begin
                                state_q <= StParity;
                                tx_q    <= parity_bit(data_q, PARITY_ODD);
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd), each fed by
// a small ring-buffer FIFO model, with a byte scoreboard and a frame decoder.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en;
    logic [2:0] empty;
    logic [2:0] rd_en;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] fd;
    logic [7:0] rdata [3];
    logic [7:0] mem [3][16];
    logic [3:0] wptr [3];
    logic [3:0] rptr [3] = '{4'd0, 4'd0, 4'd0};
    int         pops [3] = '{0, 0, 0};
    logic       bad_pop = 1'b0;
    logic [7:0] exp_q [3][$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_np (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0]), .fifo_empty_i(empty[0]),
        .fifo_read_data_i(rdata[0]), .fifo_read_en_o(rd_en[0]), .tx_o(tx[0]),
        .busy_o(busy[0]), .frame_done_o(fd[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_pe (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en[1]), .fifo_empty_i(empty[1]),
        .fifo_read_data_i(rdata[1]), .fifo_read_en_o(rd_en[1]), .tx_o(tx[1]),
        .busy_o(busy[1]), .frame_done_o(fd[1])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_po (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en[2]), .fifo_empty_i(empty[2]),
        .fifo_read_data_i(rdata[2]), .fifo_read_en_o(rd_en[2]), .tx_o(tx[2]),
        .busy_o(busy[2]), .frame_done_o(fd[2])
    );

    // FIFO model: read data appears the cycle after a pop.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k]) begin
                if (empty[k]) bad_pop <= 1'b1;
                rdata[k] <= mem[k][rptr[k]];
                rptr[k]  <= rptr[k] + 4'd1;
                pops[k]  <= pops[k] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int k = 0; k < 3; k++) empty[k] = (wptr[k] == rptr[k]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wptr[k]] = b;
        wptr[k] = wptr[k] + 4'd1;
        exp_q[k].push_back(b);
    endtask

    // Decode one frame from instance k, sampling mid-bit; returns at the
    // frame_done cycle. gap = negedges waited before the start bit appeared.
    task automatic recv_frame(input int k, input int exp_len, input logic exp_par,
                              input int drop_bit, output int gap);
        int         n;
        int         cur;
        logic [7:0] b;
        logic [7:0] exp_b;
        n = 0;
        while (tx[k] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        gap = n;
        if (tx[k] !== 1'b0) begin
            check("start_timeout", {31'd0, tx[k]}, 32'd0);
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", {31'd0, tx[k]}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = tx[k];
            if (j == drop_bit) en[k] = 1'b0;
        end
        cur = CPB * 9 + CPB / 2;
        if (k != 0) begin
            repeat (CPB) @(negedge clk);
            check("parity_bit", {31'd0, tx[k]}, {31'd0, exp_par});
            cur += CPB;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", {31'd0, tx[k]}, 32'd1);
        repeat (exp_len - 1 - cur) @(negedge clk);
        check("frame_done_early", {31'd0, fd[k]}, 32'd0);
        check("busy_in_stop", {31'd0, busy[k]}, 32'd1);
        @(negedge clk);
        check("frame_done", {31'd0, fd[k]}, 32'd1);
        check("busy_after", {31'd0, busy[k]}, 32'd0);
        exp_b = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 8'hxx;
        check("data_byte", {24'd0, b}, {24'd0, exp_b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  gap;
        int  p0;
        logic hi;
        vecs[0] = '{0, 8'hA5, 1'b0, 40};
        vecs[1] = '{1, 8'h07, 1'b1, 44};
        vecs[2] = '{2, 8'h07, 1'b0, 44};
        vecs[3] = '{1, 8'hA5, 1'b0, 44};
        vecs[4] = '{2, 8'hA5, 1'b1, 44};
        vecs[5] = '{0, 8'h00, 1'b0, 40};
        vecs[6] = '{0, 8'hFF, 1'b0, 40};
        vecs[7] = '{2, 8'h80, 1'b0, 44};

        en = '0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) wptr[k] = 4'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_tx", {31'd0, tx[k]}, 32'd1);
            check("rst_busy", {31'd0, busy[k]}, 32'd0);
            check("rst_read_en", {31'd0, rd_en[k]}, 32'd0);
            check("rst_frame_done", {31'd0, fd[k]}, 32'd0);
        end
        rst_n = 1'b1;

        // Enabled with empty FIFOs: nothing may be popped.
        en = 3'b111;
        repeat (10) @(negedge clk);
        check("no_pop_when_empty", pops[0] + pops[1] + pops[2], 0);
        check("idle_tx_high", {29'd0, tx}, 32'h7);
        en = '0;

        for (int v = 0; v < 8; v++) begin
            p0 = pops[vecs[v].inst];
            push(vecs[v].inst, vecs[v].data);
            en[vecs[v].inst] = 1'b1;
            recv_frame(vecs[v].inst, vecs[v].exp_len, vecs[v].exp_par, -1, gap);
            en[vecs[v].inst] = 1'b0;
            repeat (4) @(negedge clk);
            check("one_pop", pops[vecs[v].inst] - p0, 1);
            check("fifo_empty_after", {31'd0, empty[vecs[v].inst]}, 32'd1);
        end

        // Back-to-back frames with two idle clocks between them.
        p0 = pops[0];
        push(0, 8'd10);
        push(0, 8'd20);
        push(0, 8'd30);
        push(0, 8'd40);
        en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv_frame(0, 40, 1'b0, -1, gap);
            if (i > 0) check("b2b_gap", gap, 2);
        end
        hi = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) hi = 1'b0;
        end
        check("tx_high_when_drained", {31'd0, hi}, 32'd1);
        check("four_pops", pops[0] - p0, 4);
        en[0] = 1'b0;

        // Enable dropped during data bit 3: frame finishes, no further fetch.
        p0 = pops[0];
        push(0, 8'h5A);
        push(0, 8'hC3);
        en[0] = 1'b1;
        recv_frame(0, 40, 1'b0, 3, gap);
        repeat (12) @(negedge clk);
        check("no_pop_disabled", pops[0] - p0, 1);
        check("idle_busy_disabled", {31'd0, busy[0]}, 32'd0);
        check("idle_tx_disabled", {31'd0, tx[0]}, 32'd1);
        en[0] = 1'b1;
        recv_frame(0, 40, 1'b0, -1, gap);
        check("second_pop", pops[0] - p0, 2);
        en[0] = 1'b0;

        // Asynchronous reset mid data bit discards the in-flight byte.
        p0 = pops[0];
        push(0, 8'h3C);
        push(0, 8'hE1);
        en[0] = 1'b1;
        gap = 0;
        while (tx[0] !== 1'b0 && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        check("rst_test_started", {31'd0, tx[0]}, 32'd0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        en[0] = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx[0]}, 32'd1);
        check("async_rst_busy", {31'd0, busy[0]}, 32'd0);
        void'(exp_q[0].pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en[0] = 1'b1;
        recv_frame(0, 40, 1'b0, -1, gap);
        check("pops_after_reset", pops[0] - p0, 2);
        en[0] = 1'b0;

        check("never_pop_empty", {31'd0, bad_pop}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
